// File: rtl/master_tx.sv
// FIFO-buffered valid/ready master with a registered output stage.
// Counts completed transfers in a wrapping 16-bit counter.
module master_tx #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic [15:0]      sent_cnt,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;
  logic             xfer;
  logic             fifo_ne;

  assign fifo_ne   = count != '0;
  assign din_ready = count < CNT_FULL;
  assign push      = din_valid & din_ready;
  assign xfer      = valid & ready;
  // refill the output register when empty or emptying this edge
  assign pop       = fifo_ne & (~valid | xfer);
  assign busy      = fifo_ne | valid;

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data     <= '0;
      valid    <= 1'b0;
      sent_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        data   <= mem[rd_ptr];
        valid  <= 1'b1;
      end else if (xfer) begin
        valid  <= 1'b0;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (xfer) sent_cnt <= sent_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_master_tx.sv
// Directed bench for master_tx: latency, backpressure, full, reset,
// pointer wrap and sent_cnt wrap.
module tb_master_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic [15:0] sent_cnt;
  logic        busy;

  int errors = 0;
  int checks = 0;

  master_tx #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .data(data), .valid(valid),
    .ready(ready), .sent_cnt(sent_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] model;
    int budget;
    int rx;

    rst = 1'b1; din = 32'hDEAD; din_valid = 1'b1; ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_cnt", 32'(sent_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(din_ready), 32'd1);
    rst = 1'b0; din_valid = 1'b0;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_rdy", 32'(din_ready), 32'd1);

    // single word
    din = 32'hA5; din_valid = 1'b1; ready = 1'b1;
    step();
    din_valid = 1'b0;
    check("sw_nobypass", 32'(valid), 32'd0);
    check("sw_busy", 32'(busy), 32'd1);
    step();
    check("sw_valid", 32'(valid), 32'd1);
    check("sw_data", data, 32'hA5);
    check("sw_cnt0", 32'(sent_cnt), 32'd0);
    step();
    check("sw_valid_off", 32'(valid), 32'd0);
    check("sw_cnt1", 32'(sent_cnt), 32'd1);
    check("sw_idle", 32'(busy), 32'd0);

    // backpressure
    ready = 1'b0; din_valid = 1'b1;
    din = 32'h11; step();
    din = 32'h22; step();
    din = 32'h33; step();
    din_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_data", data, 32'h11);
      check("bp_hold_valid", 32'(valid), 32'd1);
      step();
    end
    ready = 1'b1;
    step();
    check("bp_d22", data, 32'h22);
    check("bp_c2", 32'(sent_cnt), 32'd2);
    step();
    check("bp_d33", data, 32'h33);
    check("bp_c3", 32'(sent_cnt), 32'd3);
    step();
    check("bp_done", 32'(valid), 32'd0);
    check("bp_c4", 32'(sent_cnt), 32'd4);
    check("bp_idle", 32'(busy), 32'd0);

    // fill: 5 accepted (4 in FIFO + output register)
    ready = 1'b0; din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 32'h100 + 32'(i);
      step();
      check("full_rdy", 32'(din_ready), (i < 4) ? 32'd1 : 32'd0);
    end
    din = 32'h105;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_hold_rdy", 32'(din_ready), 32'd0);
      check("full_hold_data", data, 32'h100);
    end

    // full with simultaneous pop: push ignored
    ready = 1'b1;
    step();
    check("fp_data", data, 32'h101);
    check("fp_rdy", 32'(din_ready), 32'd1);
    check("fp_cnt", 32'(sent_cnt), 32'd5);
    step();
    din_valid = 1'b0;
    for (int i = 2; i < 6; i++) begin
      check("fp_order", data, 32'h100 + 32'(i));
      check("fp_valid", 32'(valid), 32'd1);
      step();
    end
    check("fp_drained", 32'(valid), 32'd0);
    check("fp_c10", 32'(sent_cnt), 32'd10);
    check("fp_idle", 32'(busy), 32'd0);

    // reset mid-operation
    ready = 1'b0; din_valid = 1'b1;
    din = 32'h7; step();
    din = 32'h8; step();
    din = 32'h9; step();
    din_valid = 1'b0;
    step();
    check("mr_pre_valid", 32'(valid), 32'd1);
    check("mr_pre_data", data, 32'h7);
    rst = 1'b1; ready = 1'b1; din_valid = 1'b1; din = 32'hBAD;
    step();
    rst = 1'b0; din_valid = 1'b0;
    check("mr_valid", 32'(valid), 32'd0);
    check("mr_data", data, 32'd0);
    check("mr_cnt", 32'(sent_cnt), 32'd0);
    check("mr_rdy", 32'(din_ready), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) step();
    check("mr_no_old", 32'(valid), 32'd0);
    check("mr_cnt_still0", 32'(sent_cnt), 32'd0);

    // pointer wrap: 3*DEPTH words in order
    rx = 0;
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din_valid = (i < 12);
      din = 32'hC00 + 32'(i);
      step();
      if (valid) begin
        check("wrap_order", data, 32'hC00 + 32'(rx));
        rx++;
      end
    end
    check("wrap_count", 32'(rx), 32'd12);
    check("wrap_sent", 32'(sent_cnt), 32'd12);

    // sent_cnt wrap
    model = 16'd12;
    budget = 0;
    din_valid = 1'b1;
    while (model != 16'hFFFF && budget < 70000) begin
      din = din + 32'd1;
      if (valid && ready) model++;
      step();
      budget++;
    end
    check("pre_timeout", 32'(budget < 70000), 32'd1);
    check("pre_ffff", 32'(sent_cnt), 32'hFFFF);
    check("pre_valid", 32'(valid), 32'd1);
    din_valid = 1'b0;
    step();
    check("cnt_wrap", 32'(sent_cnt), 32'h0000);
    budget = 0;
    while (busy && budget < 20) begin
      step();
      budget++;
    end
    check("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/master_tx.md
MASTER_TX -- requirements
Module: master_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning internal FIFO depth in words; a power of two, at least 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port din  input  WIDTH  source write data.
REQ-006 SHALL have port din_valid  input  1  source write request.
REQ-007 SHALL have port din_ready  output  1  FIFO can accept a word: high when count < DEPTH.
REQ-008 SHALL have port data  output  WIDTH  handshake data to the downstream slave.
REQ-009 SHALL have port valid  output  1  handshake valid to the downstream slave.
REQ-010 SHALL have port ready  input  1  handshake ready from the downstream slave.
REQ-011 SHALL have port sent_cnt  output  16  count of completed transfers.
REQ-012 SHALL have port busy  output  1  high when the FIFO is non-empty or valid is high.

Function
REQ-013 SHALL write din into the FIFO on a rising edge where din_valid=1 and din_ready=1 ("push").
REQ-014 SHALL hold the output stage as a register pair (data, valid), loaded from the FIFO head ("pop").
REQ-015 SHALL count a transfer on a rising edge where valid=1 and ready=1.
REQ-016 SHALL pop when the FIFO is non-empty and either valid=0 or a transfer occurs on the same edge; a pop sets valid=1.
REQ-017 SHALL clear valid on a transfer edge when the FIFO is empty.
REQ-018 SHALL keep data and valid unchanged while valid=1 and ready=0; valid SHALL never drop without a transfer.
REQ-019 SHALL never derive valid combinationally from ready.
REQ-020 SHALL have latency: a word pushed at edge N into an empty FIFO with valid=0 appears on data with valid=1 after edge N+1; there is no bypass path.
REQ-021 SHALL, with ready held high, sustain one transfer per cycle while the FIFO is non-empty.
REQ-022 SHALL have a total buffering capacity of DEPTH+1 words (FIFO plus output register).
REQ-023 SHALL ignore a push while full, even when a pop occurs on the same edge; din_ready is derived from the current count only.
REQ-024 SHALL, on a simultaneous push and pop, leave count unchanged and preserve word order.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH; count spans 0..DEPTH.
REQ-026 SHALL increment sent_cnt by 1 per transfer, wrapping from 0xFFFF to 0x0000.
REQ-027 SHALL preserve strict FIFO order: data values are transmitted in push order with no loss or duplication.

Reset
REQ-028 SHALL, while rst=1 at a rising edge, set valid=0, data=0, FIFO count=0, both pointers=0 and sent_cnt=0.
REQ-029 SHALL ignore din_valid and ready while rst=1; no push and no transfer are counted.
REQ-030 SHALL, on reset mid-operation, discard all buffered words, including a word held in the output register awaiting ready.
REQ-031 SHALL present din_ready=1 and busy=0 on the first cycle after rst deasserts.

Verification
REQ-032 Single word: push 0x0000_00A5 into an idle block with ready=1 -> valid=1 and data=0xA5 for exactly one cycle after edge N+1; sent_cnt=1; busy=0 afterwards.
REQ-033 Backpressure: push 0x11, 0x22, 0x33 with ready=0 for 10 cycles -> data stays 0x11 with valid=1 throughout; on releasing ready, 0x11, 0x22, 0x33 transfer on consecutive cycles.
REQ-034 Full: with ready=0, push 6 words -> the first 5 are accepted (4 in FIFO, 1 in output register); din_ready=0 from then on; the 6th is not taken until a transfer occurs.
REQ-035 Full with simultaneous pop: FIFO full, ready=1 and din_valid=1 on the same edge -> one transfer, no push, count becomes DEPTH-1; din_ready=1 on the next cycle.
REQ-036 Reset mid-operation: 3 words buffered, valid=1 and ready=0, then assert rst for one edge -> valid=0, data=0, sent_cnt=0, din_ready=1; the old words never appear.
REQ-037 Wrap: preload sent_cnt to 0xFFFF via 65535 transfers, then perform 1 more -> sent_cnt=0x0000; pointer wrap verified by streaming 3×DEPTH words in order.
